// File: rtl/uart_rx_port_if.sv
// CPU-side register bus of the serial receiver: strobe-qualified single-cycle accesses.
// The CPU drives the master side; the receiver is the slave responder.
interface uart_rx_port_if;
    logic       bus_strobe;
    logic       bus_sel;
    logic       bus_addr;
    logic       bus_we;
    logic [7:0] bus_data_in;
    logic [7:0] bus_data_out;

    modport master (
        output bus_strobe,
        output bus_sel,
        output bus_addr,
        output bus_we,
        output bus_data_in,
        input  bus_data_out
    );

    modport slave (
        input  bus_strobe,
        input  bus_sel,
        input  bus_addr,
        input  bus_we,
        input  bus_data_in,
        output bus_data_out
    );
endinterface

// File: rtl/uart_rx_port.sv
// 8N1 serial receiver feeding a small FIFO, read by the CPU through DATA/STATUS registers.
// Everything runs on dot_clk; bus accesses arrive as one-cycle strobes.
module uart_rx_port #(
    parameter int unsigned CLK_DIV = 217,
    parameter int unsigned FIFO_AW = 2
) (
    input  logic            dot_clk,
    input  logic            reset_n,
    input  logic            rx,
    uart_rx_port_if.slave   bus,
    output logic            irq
);
    localparam int unsigned CW    = $clog2(CLK_DIV);
    localparam int unsigned DEPTH = 1 << FIFO_AW;

    // The counter expires on the cycle it reads zero, so loads are one short of the interval.
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [FIFO_AW:0]   COUNT_FULL = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0]   COUNT_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    rx_state_t state, state_next;

    logic          rx_m, rx_s, rx_s_d;
    logic [1:0]    sync_fill;
    logic          armed;
    logic          falling;

    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]    bit_idx, bit_idx_next;
    logic [7:0]    shreg, shreg_next;
    logic          tick;
    logic          push_req;
    logic          ferr_set;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wptr, rptr;
    logic [FIFO_AW:0]   count;
    logic               empty, full;
    logic               overrun, framing_err;

    logic       rd, wr;
    logic       pop, push_ok, ovr_set;
    logic       clr_ovr, clr_ferr;
    logic [7:0] status;
    logic       unused_wdata;

    // Edges are only trusted once a real high has come through the synchroniser,
    // so a line already low at reset release cannot fake a start bit.
    assign falling = armed & rx_s_d & ~rx_s;

    always_ff @(posedge dot_clk) begin
        if (!reset_n) begin
            rx_m      <= 1'b1;
            rx_s      <= 1'b1;
            rx_s_d    <= 1'b1;
            sync_fill <= '0;
            armed     <= 1'b0;
        end else begin
            rx_m      <= rx;
            rx_s      <= rx_m;
            rx_s_d    <= rx_s;
            sync_fill <= {sync_fill[0], 1'b1};
            armed     <= armed | (sync_fill[1] & rx_s);
        end
    end

    assign tick = (cnt == '0);

    always_ff @(posedge dot_clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_idx_next;
            shreg   <= shreg_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bit_idx_next = bit_idx;
        shreg_next   = shreg;
        push_req     = 1'b0;
        ferr_set     = 1'b0;
        case (state)
            IDLE: begin
                if (falling) begin
                    cnt_next   = HALF_LOAD;
                    state_next = START;
                end
            end
            START: begin
                if (!tick) begin
                    cnt_next = cnt - CNT_ONE;
                end else if (!rx_s) begin
                    cnt_next     = FULL_LOAD;
                    bit_idx_next = '0;
                    state_next   = DATA;
                end else begin
                    state_next = IDLE;
                end
            end
            DATA: begin
                if (!tick) begin
                    cnt_next = cnt - CNT_ONE;
                end else begin
                    shreg_next   = {rx_s, shreg[7:1]};
                    cnt_next     = FULL_LOAD;
                    bit_idx_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (!tick) begin
                    cnt_next = cnt - CNT_ONE;
                end else begin
                    push_req   = rx_s;
                    ferr_set   = ~rx_s;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign rd = bus.bus_strobe & bus.bus_sel & ~bus.bus_we;
    assign wr = bus.bus_strobe & bus.bus_sel &  bus.bus_we;

    assign empty = (count == '0);
    assign full  = (count == COUNT_FULL);
    assign irq   = ~empty;

    // A pop in the same cycle frees the slot a full FIFO needs for the incoming byte.
    assign pop     = rd & ~bus.bus_addr & ~empty;
    assign push_ok = push_req & (~full | pop);
    assign ovr_set = push_req & full & ~pop;

    assign clr_ovr  = wr & bus.bus_addr & bus.bus_data_in[2];
    assign clr_ferr = wr & bus.bus_addr & bus.bus_data_in[3];

    assign unused_wdata = ^{bus.bus_data_in[7:4], bus.bus_data_in[1:0]};

    assign status = {3'b000, (state != IDLE), framing_err, overrun, full, ~empty};

    always_ff @(posedge dot_clk) begin
        if (reset_n && push_ok) begin
            mem[wptr] <= shreg;
        end
    end

    always_ff @(posedge dot_clk) begin
        if (!reset_n) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            overrun     <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + PTR_ONE;
            end
            if (pop) begin
                rptr <= rptr + PTR_ONE;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
            overrun     <= ovr_set  | (overrun     & ~clr_ovr);
            framing_err <= ferr_set | (framing_err & ~clr_ferr);
        end
    end

    always_ff @(posedge dot_clk) begin
        if (!reset_n) begin
            bus.bus_data_out <= '0;
        end else if (rd) begin
            if (bus.bus_addr) begin
                bus.bus_data_out <= status;
            end else if (!empty) begin
                bus.bus_data_out <= mem[rptr];
            end else begin
                bus.bus_data_out <= '0;
            end
        end
    end
endmodule

// File: doc/uart_rx_port.md
Name: uart_rx_port

Overview:
- Memory-mapped serial receiver.
- Deserialises an asynchronous 8N1 line into a small FIFO.
- Presents DATA and STATUS registers to the CPU bus as a read-side responder, the input counterpart to the write-only IO port latch.
- Runs entirely in the dot_clk domain. The top level qualifies CPU bus cycles into one-dot_clk strobes while cpu_clk is low.

Parameters:
- CLK_DIV, 217, dot_clk cycles per bit (25 MHz / 115200); minimum 4.
- FIFO_AW, 2, log2 of FIFO depth (4 entries).

Ports:
- dot_clk  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- rx  input  1  asynchronous serial line; idles high.
- bus_strobe  input  1  one-dot_clk pulse per CPU bus access.
- bus_sel  input  1  address decode hit for this block.
- bus_addr  input  1  register select: 0 = DATA, 1 = STATUS.
- bus_we  input  1  1 = CPU write, 0 = CPU read.
- bus_data_in  input  8  CPU write data.
- bus_data_out  output  8  registered read data.
- irq  output  1  level; high while the FIFO is non-empty.

Behaviour:
- Reset (reset_n low at a rising edge):
  - bus_data_out=0x00, irq=0.
  - FIFO empty (pointers 0, count 0); overrun=0, framing_err=0.
  - FSM in IDLE; both rx synchroniser flops=1.
- Input synchroniser: rx passes through 2 flops to give rx_s. A falling edge is rx_s low with the previous rx_s high.
- FSM states and transitions:
  - IDLE: on a falling edge, load bit counter with CLK_DIV/2 (integer divide) and go to START.
  - START: count down to 0, then resample rx_s.
    - Low: load CLK_DIV, bit index 0, go to DATA.
    - High: glitch; return to IDLE, no flags set.
  - DATA: on each countdown expiry, shift rx_s into the shift register LSB first and reload CLK_DIV. After the 8th bit, go to STOP.
  - STOP: on expiry, sample rx_s.
    - High: push the byte.
    - Low: set framing_err and discard the byte.
    - Either way, go to IDLE.
  - Sampling points: middle of each bit ±1 dot_clk.
- Push rules:
  - FIFO not full: write the byte, count+1.
  - FIFO full and a pop in the same cycle: the push is accepted and count is unchanged.
  - FIFO full and no pop: drop the byte and set overrun.
- Read (bus_strobe & bus_sel & ~bus_we): bus_data_out updates on the next rising edge (latency 1) and holds until the next read.
  - DATA, non-empty: head byte returned, FIFO popped (count-1) in the same cycle.
  - DATA, empty: 0x00 returned, no pop, no error.
  - STATUS:
    - bit0 not_empty, bit1 full, bit2 overrun, bit3 framing_err.
    - bit4 rx_busy (FSM not IDLE).
    - bits7:5 = 0.
  - A STATUS read has no side effects.
- Write (bus_strobe & bus_sel & bus_we):
  - STATUS: writing 1 to bit2 clears overrun; writing 1 to bit3 clears framing_err; other bits ignored.
  - DATA: ignored.
  - If a clear coincides with a new error event in the same cycle, set wins.
- Strobe gating: when bus_strobe is low or bus_sel is low, there is no register effect and bus_data_out holds.
- Pointers: wrap modulo 2^FIFO_AW. full = (count == 2^FIFO_AW); count width is FIFO_AW+1.
- irq is combinational from the count (count != 0).
- Reset mid-frame: the partial byte is lost, the FSM returns to IDLE, and the FIFO is emptied. A line held low after reset does not start a frame until a high-to-low edge is seen.

Test Plan:
- CLK_DIV=8. Send byte 0xA5 (8N1) on rx, then read STATUS → 0x01 and irq=1. Read DATA → 0xA5. Read STATUS → 0x00 and irq=0.
- Send 0x01,0x02,0x03,0x04,0x55 with no reads:
  - STATUS → 0x07 (not_empty, full, overrun).
  - Four DATA reads → 0x01..0x04; fifth DATA read → 0x00.
  - Write 0x04 to STATUS, then STATUS → 0x00.
- Send 0x3C with the stop bit driven low → STATUS 0x08, FIFO empty. Write 0x08 to STATUS clears it to 0x00.
- Pulse rx low for 2 dot_clk then hold high → FSM returns to IDLE from START; STATUS stays 0x00 and no byte is pushed.
- Fill the FIFO with 4 bytes and time a DATA read to land on the same cycle as the STOP-sample push of a 5th byte (0x77) → overrun stays 0, count stays 4, and the 5th read returns 0x77.
- Assert reset_n low for 1 cycle midway through the DATA bits of a frame → bus_data_out=0x00, STATUS 0x00, and no byte is pushed from the truncated frame.
